// File: rtl/spi_pkg.sv
// Shared constants for the framed SPI slave:
// CRC-8 SAE-J1850 defaults and FSM state encoding.
package spi_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h1D;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/crc_serial.sv
// Bit-serial CRC, MSB first, no reflection, no final XOR.
// Ports: clk, rstn, clr (reseed), en (absorb bit_in), bit_in, crc.
module crc_serial
  import spi_pkg::*;
#(
  parameter int              CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC8_POLY,
  parameter logic [CRC_W-1:0] CRC_INIT = CRC8_INIT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] nxt;
  logic             fb;

  // clr and en may coincide: the seed absorbs the bit in that cycle
  always_comb begin
    base = clr ? CRC_INIT : crc;
    fb   = base[CRC_W-1] ^ bit_in;
    nxt  = base;
    if (en)
      nxt = (base << 1) ^ (fb ? CRC_POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      crc <= CRC_INIT;
    else
      crc <= nxt;
  end

endmodule

// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave moving DATA_W payload + CRC_W CRC bits per frame.
// Ports: SPI pins (sck, csn, si, so), tx/rx valid-ready streams, error pulses.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int                DATA_W   = 24,
  parameter int                CRC_W    = 8,
  parameter logic [CRC_W-1:0]  CRC_POLY = CRC8_POLY,
  parameter logic [CRC_W-1:0]  CRC_INIT = CRC8_INIT,
  parameter bit                CPOL     = 1'b0,
  parameter bit                CPHA     = 1'b0,
  parameter logic [DATA_W-1:0] TX_IDLE  = 24'hEFEFEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sck,
  input  logic              csn,
  input  logic              si,
  output logic              so,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              crc_err,
  output logic              frame_err,
  output logic              tx_underrun,
  output logic              rx_overrun
);

  localparam int TOT = DATA_W + CRC_W;
  localparam int CW  = $clog2(TOT + 2);
  localparam int TW  = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] TOT_C = CW'(TOT);
  localparam logic [CW-1:0] SAT_C = CW'(TOT + 1);
  localparam logic [CW-1:0] DWC_C = CW'(DATA_W);
  localparam logic [TW-1:0] DWT_C = TW'(DATA_W);

  logic [2:0]        sck_r;
  logic [2:0]        csn_r;
  logic [2:0]        si_r;
  logic              lead_p;
  logic              trail_p;
  logic              fall_p;
  logic              rise_p;
  logic              samp;
  logic              shft;
  state_t            state_q;
  state_t            state_d;
  logic              start;
  logic              done;
  logic              hold_valid;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] tx_src;
  logic [DATA_W-1:0] tx_sr;
  logic [CRC_W-1:0]  crc_sr;
  logic [CRC_W-1:0]  tx_crc;
  logic [CRC_W-1:0]  rx_crc;
  logic [TW-1:0]     tx_cnt;
  logic [CW-1:0]     bit_cnt;
  logic [TOT-1:0]    rx_sr;
  logic              tx_drive;
  logic              tx_crc_en;
  logic              tx_crc_bit;
  logic              rx_crc_en;

  assign tx_ready = !hold_valid;
  assign samp     = CPHA ? trail_p : lead_p;
  assign shft     = CPHA ? lead_p : trail_p;

  // [1] is the synchronised value, [2] its previous sample;
  // edge pulses are registered so si_r[2] lines up with them
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sck_r   <= {3{CPOL}};
      csn_r   <= '0;
      si_r    <= '0;
      lead_p  <= 1'b0;
      trail_p <= 1'b0;
      fall_p  <= 1'b0;
      rise_p  <= 1'b0;
    end else begin
      sck_r   <= {sck_r[1:0], sck};
      csn_r   <= {csn_r[1:0], csn};
      si_r    <= {si_r[1:0], si};
      lead_p  <= (sck_r[1] != CPOL) && (sck_r[2] == CPOL);
      trail_p <= (sck_r[1] == CPOL) && (sck_r[2] != CPOL);
      fall_p  <= !csn_r[1] && csn_r[2];
      rise_p  <= csn_r[1] && !csn_r[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall_p) begin
          state_d = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (rise_p) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_src     = hold_valid ? hold : TX_IDLE;
    tx_drive   = (state_q == SHIFT) && shft;
    tx_crc_en  = (start && !CPHA) ||
                 (tx_drive && (tx_cnt < DWT_C));
    tx_crc_bit = start ? tx_src[DATA_W-1]
                       : tx_sr[DATA_W-1];
    rx_crc_en  = (state_q == SHIFT) && samp &&
                 (bit_cnt < DWC_C);
  end

  crc_serial #(
    .CRC_W   (CRC_W),
    .CRC_POLY(CRC_POLY),
    .CRC_INIT(CRC_INIT)
  ) u_tx_crc (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start),
    .en    (tx_crc_en),
    .bit_in(tx_crc_bit),
    .crc   (tx_crc)
  );

  crc_serial #(
    .CRC_W   (CRC_W),
    .CRC_POLY(CRC_POLY),
    .CRC_INIT(CRC_INIT)
  ) u_rx_crc (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (start),
    .en    (rx_crc_en),
    .bit_in(si_r[2]),
    .crc   (rx_crc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      so          <= 1'b0;
      tx_sr       <= '0;
      crc_sr      <= '0;
      tx_cnt      <= '0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;

      if (tx_valid && !hold_valid) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end else if (start) begin
        hold_valid <= 1'b0;
      end

      if (start) begin
        tx_underrun <= !hold_valid;
        crc_sr      <= '0;
        bit_cnt     <= '0;
        if (CPHA) begin
          tx_sr  <= tx_src;
          tx_cnt <= '0;
        end else begin
          so     <= tx_src[DATA_W-1];
          tx_sr  <= tx_src << 1;
          tx_cnt <= TW'(1);
        end
      end else if (tx_drive) begin
        // payload, then CRC snapshot, then zeros
        // falling out of the emptied crc_sr
        unique case (1'b1)
          (tx_cnt < DWT_C): begin
            so    <= tx_sr[DATA_W-1];
            tx_sr <= tx_sr << 1;
          end
          (tx_cnt == DWT_C): begin
            so     <= tx_crc[CRC_W-1];
            crc_sr <= tx_crc << 1;
          end
          default: begin
            so     <= crc_sr[CRC_W-1];
            crc_sr <= crc_sr << 1;
          end
        endcase
        if (tx_cnt <= DWT_C)
          tx_cnt <= tx_cnt + TW'(1);
      end

      if ((state_q == SHIFT) && samp) begin
        rx_sr <= {rx_sr[TOT-2:0], si_r[2]};
        if (bit_cnt != SAT_C)
          bit_cnt <= bit_cnt + CW'(1);
      end

      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;

      if (done) begin
        if (bit_cnt != TOT_C) begin
          frame_err <= 1'b1;
        end else if (rx_sr[CRC_W-1:0] != rx_crc) begin
          crc_err <= 1'b1;
        end else if (rx_valid && !rx_ready) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_sr[TOT-1:CRC_W];
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule
